// File: rtl/spin_readout.sv
// -----------------------------------------------------------------------------
// spin_readout
//
// Decodes the phase of each free-running oscillator relative to oscillator 0
// into a binary spin. After an accepted start the block waits a programmable
// settle time, then counts, over a programmable window, the cycles on which
// each synchronized oscillator bit agrees with oscillator 0. At the end it
// publishes the raw agreement counts and the decoded spins together with a
// one-cycle valid pulse.
//
// Parameters:
//   N            number of oscillators (bit 0 is the phase reference)
//   COUNT_WIDTH  width of the settle/measure lengths and agreement counters
//   SYNC_STAGES  flops per synchronizer chain on osc_in (must be >= 2)
//
// Ports:
//   clk             system clock
//   rst             synchronous, active-high reset
//   start           begin a readout (only looked at while idle)
//   settle_cycles   cycles to wait before measuring (latched on start)
//   measure_cycles  length of the measurement window (latched on start)
//   osc_in          asynchronous oscillator outputs, bit i = oscillator i
//   busy            high while a readout is in progress (settle/measure/done)
//   valid           one-cycle pulse when spins/agree_counts are refreshed
//   spins           decoded spins, bit 0 always 0
//   agree_counts    per-oscillator agreement counts, oscillator i at
//                   [i*COUNT_WIDTH +: COUNT_WIDTH]
// -----------------------------------------------------------------------------
module spin_readout #(
    parameter int N           = 3,
    parameter int COUNT_WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [COUNT_WIDTH-1:0]   settle_cycles,
    input  logic [COUNT_WIDTH-1:0]   measure_cycles,
    input  logic [N-1:0]             osc_in,
    output logic                     busy,
    output logic                     valid,
    output logic [N-1:0]             spins,
    output logic [N*COUNT_WIDTH-1:0] agree_counts
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [N-1:0]             r_sync [SYNC_STAGES];
    logic [N-1:0]             w_s;

    logic [COUNT_WIDTH-1:0]   r_s_len;
    logic [COUNT_WIDTH-1:0]   r_m_len;
    logic [COUNT_WIDTH-1:0]   r_cnt;
    logic [COUNT_WIDTH-1:0]   w_cnt_next;
    logic [COUNT_WIDTH-1:0]   w_m_eff;

    logic [COUNT_WIDTH-1:0]   r_acc      [N];
    logic [COUNT_WIDTH-1:0]   w_acc_next [N];
    logic [N-1:0]             w_spins;
    logic [N*COUNT_WIDTH-1:0] w_acc_flat;

    logic [N-1:0]             r_spins;
    logic [N*COUNT_WIDTH-1:0] r_agree;

    // ------------------------------------------------------------------
    // Synchronizer: osc_in is only ever consumed through the last stage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= osc_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Next-state / cycle counter. r_cnt counts cycles spent in the current
    // timed state and wraps to 0 on every exit, so each timed state starts
    // from a clean count.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_m_eff      = r_m_len;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                // A start that goes straight to DONE (S=0, M=0) never latches
                // M before the output load, so use the live input here.
                w_m_eff    = measure_cycles;
                if (start) begin
                    if (settle_cycles != '0) begin
                        w_state_next = ST_SETTLE;
                    end else if (measure_cycles != '0) begin
                        w_state_next = ST_MEASURE;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_SETTLE: begin
                if (r_cnt == r_s_len - 1'b1) begin
                    w_cnt_next   = '0;
                    w_state_next = (r_m_len != '0) ? ST_MEASURE : ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (r_cnt == r_m_len - 1'b1) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-oscillator accumulators and spin decision. The outputs are loaded
    // from the next accumulator value on the edge entering DONE, so the last
    // measurement cycle is included and the data is visible while valid=1.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_osc
            always_comb begin
                w_acc_next[gi] = r_acc[gi];
                if (r_state == ST_IDLE) begin
                    w_acc_next[gi] = '0;
                end else if ((r_state == ST_MEASURE) && (w_s[gi] == w_s[0])) begin
                    w_acc_next[gi] = r_acc[gi] + 1'b1;
                end
            end

            // 2*acc < M at COUNT_WIDTH+1 bits; a tie or M=0 yields spin 0.
            assign w_spins[gi] = ({w_acc_next[gi], 1'b0} < {1'b0, w_m_eff});
            assign w_acc_flat[gi*COUNT_WIDTH +: COUNT_WIDTH] = w_acc_next[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_s_len <= '0;
            r_m_len <= '0;
            r_spins <= '0;
            r_agree <= '0;
            for (int k = 0; k < N; k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            for (int k = 0; k < N; k++) begin
                r_acc[k] <= w_acc_next[k];
            end
            if ((r_state == ST_IDLE) && start) begin
                r_s_len <= settle_cycles;
                r_m_len <= measure_cycles;
            end
            if ((w_state_next == ST_DONE) && (r_state != ST_DONE)) begin
                r_spins <= w_spins;
                r_agree <= w_acc_flat;
            end
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign valid        = (r_state == ST_DONE);
    assign spins        = r_spins;
    assign agree_counts = r_agree;

endmodule

// File: tb/tb_spin_readout.sv
// -----------------------------------------------------------------------------
// tb_spin_readout
//
// Table-driven plus randomized bench for spin_readout (N=3). Each readout is
// framed by the bench: it knows the cycle on which start is accepted, drives
// the oscillator pattern cycle by cycle (remembering every driven value), and
// checks busy/valid on every cycle and spins/agree_counts on the valid cycle.
// Randomized patterns are judged by a model that counts agreement directly
// over the remembered osc_in history, shifted by the synchronizer depth.
// -----------------------------------------------------------------------------
module tb_spin_readout;
    localparam int N    = 3;
    localparam int CW   = 16;
    localparam int SS   = 2;
    localparam int HIST = 4096;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [CW-1:0]       settle_cycles;
    logic [CW-1:0]       measure_cycles;
    logic [N-1:0]        osc_in;
    logic                busy;
    logic                valid;
    logic [N-1:0]        spins;
    logic [N*CW-1:0]     agree_counts;

    spin_readout #(
        .N           (N),
        .COUNT_WIDTH (CW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .settle_cycles  (settle_cycles),
        .measure_cycles (measure_cycles),
        .osc_in         (osc_in),
        .busy           (busy),
        .valid          (valid),
        .spins          (spins),
        .agree_counts   (agree_counts)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [N-1:0] hist [HIST];

    // mode 0: all zero; 1: osc0 toggles every 3 clk, osc1=~osc0, osc2=osc0;
    // 2: osc1 agrees with osc0 on the first 'param' window cycles only;
    // 3: random bits every cycle (judged by the model).
    typedef struct {
        int         s;
        int         m;
        int         mode;
        int         param;
        bit         poke;
        bit         rst_mid;
        bit         use_model;
        logic [2:0] exp_spins;
        int         e0;
        int         e1;
        int         e2;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string what, input int idx,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (case %0d, cycle %0d): got %0h, expected %0h",
                     what, idx, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [N-1:0] pattern(input int mode, input int param,
                                             input int j, input int c);
        logic [N-1:0] v;
        logic         b;
        v = '0;
        case (mode)
            1: begin
                b = ((c / 3) % 2) == 1;
                v = {b, ~b, b};
            end
            2: v = (j >= 0 && j < param) ? 3'b000 : 3'b010;
            3: v = N'($urandom);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Agreement over measure cycles [a+s, a+s+m); s[] seen in cycle c is
    // the osc_in value driven SS cycles earlier.
    task automatic model(input int a, input int s, input int m,
                         output logic [N-1:0] sp, output logic [N*CW-1:0] cnts);
        int acc [N];
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) acc[i] = 0;
        for (int c = a + s; c < a + s + m; c++) begin
            v = hist[c - SS];
            for (int i = 0; i < N; i++) begin
                if (v[i] == v[0]) acc[i]++;
            end
        end
        for (int i = 0; i < N; i++) begin
            sp[i] = (2 * acc[i] < m);
            cnts[i*CW +: CW] = CW'(acc[i]);
        end
    endtask

    task automatic run_case(input int idx, input vec_t v);
        int a, last, stop;
        logic [N-1:0]    esp;
        logic [N*CW-1:0] ecnt;
        a    = cyc + 4;                 // edge on which start is accepted
        last = a + v.s + v.m;           // sample showing DONE/valid
        stop = last + 1 + (v.poke ? 15 : 0);
        esp  = v.exp_spins;
        ecnt = {CW'(v.e2), CW'(v.e1), CW'(v.e0)};
        forever begin
            tick();
            if (v.rst_mid && cyc == a + v.s + 3) begin
                check("rst_busy", idx, busy, 0);
                check("rst_valid", idx, valid, 0);
                check("rst_spins", idx, spins, 0);
                check("rst_counts", idx, agree_counts, 0);
                rst    = 1'b0;
                osc_in = '0;
                hist[cyc] = osc_in;
                return;
            end
            check("busy", idx, busy, (cyc >= a && cyc <= last));
            check("valid", idx, valid, (cyc == last));
            if (cyc == last) begin
                if (v.use_model) model(a, v.s, v.m, esp, ecnt);
                check("spins", idx, spins, esp);
                check("agree_counts", idx, agree_counts, ecnt);
            end
            if (cyc == stop) break;
            start = (cyc == a - 1) || (v.poke && cyc == a + v.s + v.m / 2);
            if (cyc == a - 1) begin
                settle_cycles  = CW'(v.s);
                measure_cycles = CW'(v.m);
            end else begin
                settle_cycles  = CW'($urandom);
                measure_cycles = CW'($urandom);
            end
            rst       = v.rst_mid && (cyc == a + v.s + 2);
            osc_in    = pattern(v.mode, v.param, cyc + SS - (a + v.s), cyc);
            hist[cyc] = osc_in;
        end
        start = 1'b0;
    endtask

    initial begin
        int   a;
        vec_t rv;

        //             s   m  mode par poke rst mdl spins  c0  c1  c2
        tbl[0]  = '{   4, 10,  0,  0,  0,   0,  0, 3'b000, 10, 10, 10};
        tbl[1]  = '{   8, 30,  1,  0,  0,   0,  0, 3'b010, 30,  0, 30};
        tbl[2]  = '{   0, 10,  2,  5,  0,   0,  0, 3'b000, 10,  5, 10};
        tbl[3]  = '{   0, 10,  2,  4,  0,   0,  0, 3'b010, 10,  4, 10};
        tbl[4]  = '{   0,  0,  0,  0,  0,   0,  0, 3'b000,  0,  0,  0};
        tbl[5]  = '{   0,  1,  0,  0,  0,   0,  0, 3'b000,  1,  1,  1};
        tbl[6]  = '{   2, 10,  0,  0,  1,   0,  0, 3'b000, 10, 10, 10};
        tbl[7]  = '{   3,  7,  2,  3,  0,   0,  0, 3'b010,  7,  3,  7};
        tbl[8]  = '{   1, 20,  1,  0,  0,   1,  0, 3'b000,  0,  0,  0};
        tbl[9]  = '{   0,  9,  1,  0,  0,   0,  0, 3'b010,  9,  0,  9};
        tbl[10] = '{   2,  8,  2,  4,  0,   0,  0, 3'b000,  8,  4,  8};
        tbl[11] = '{   1,  1,  1,  0,  0,   0,  0, 3'b010,  1,  0,  1};

        rst            = 1'b1;
        start          = 1'b0;
        settle_cycles  = '0;
        measure_cycles = '0;
        osc_in         = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            hist[cyc] = '0;
        end
        check("reset_busy", -1, busy, 0);
        check("reset_valid", -1, valid, 0);
        check("reset_spins", -1, spins, 0);
        check("reset_counts", -1, agree_counts, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_case(i, tbl[i]);
        end

        // start held high: back-to-back readouts with one idle cycle between.
        a = cyc + 2;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (cyc >= a) begin
                check("held_busy", 100, busy,
                      (cyc >= a && cyc <= a + 3) || (cyc >= a + 5 && cyc <= a + 8));
                check("held_valid", 100, valid, (cyc == a + 3) || (cyc == a + 8));
                if (cyc == a + 8) check("held_counts", 100, agree_counts, {16'd2, 16'd2, 16'd2});
            end
            start          = (cyc >= a - 1 && cyc <= a + 7);
            settle_cycles  = 16'd1;
            measure_cycles = 16'd2;
            osc_in         = '0;
            hist[cyc]      = '0;
        end
        start = 1'b0;

        for (int i = 0; i < 12; i++) begin
            rv = '{$urandom_range(0, 6), $urandom_range(0, 40), 3, 0, 0, 0, 1,
                   3'b000, 0, 0, 0};
            run_case(200 + i, rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
